// File: rtl/cs_ip_pkg.sv
// Shared definitions for the checksum generator and its checker: state encoding,
// frame geometry helpers and the ones-complement end-around fold.
package cs_ip_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_FOLD = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ACC  = ST_ACC,
    S_FOLD = ST_FOLD,
    S_OUT  = ST_OUT
  } state_t;

  function automatic int nseg_f(input int width_data, input int seg_w);
    return width_data / seg_w;
  endfunction

  function automatic int cnt_w_f(input int nseg);
    return $clog2(nseg);
  endfunction

  // Repeatedly adds the bits above seg_w back into the low seg_w bits.
  function automatic logic [63:0] oc_fold(input logic [63:0] v, input int seg_w);
    logic [63:0] mask;
    logic [63:0] r;
    mask = (64'd1 << seg_w) - 64'd1;
    r    = v;
    for (int i = 0; i < 4; i++) begin
      r = (r & mask) + (r >> seg_w);
    end
    return r;
  endfunction

endpackage

// File: rtl/cs_oc_adder.sv
// Combinational ones-complement adder: folded running sum plus SPC segments,
// producing a SEG_W result with all carries wrapped around.
module cs_oc_adder
  import cs_ip_pkg::*;
#(
  parameter int SEG_W = 16,
  parameter int SPC   = 1
) (
  input  logic [SEG_W-1:0]     acc,
  input  logic [SPC*SEG_W-1:0] segs,
  output logic [SEG_W-1:0]     sum
);

  localparam int ACC_W = SEG_W + $clog2(SPC + 1) + 1;

  logic [ACC_W-1:0] total;

  always_comb begin
    total = ACC_W'(acc);
    for (int j = 0; j < SPC; j++) begin
      total = total + ACC_W'(segs[j*SEG_W +: SEG_W]);
    end
    sum = SEG_W'(oc_fold(64'(total), SEG_W));
  end

endmodule

// File: rtl/cs_ip_gen.sv
// Checksum generator: accumulates payload segments SPC at a time, then emits the
// frame with segment 0 replaced by the inverted ones-complement sum.
module cs_ip_gen
  import cs_ip_pkg::*;
#(
  parameter int WIDTH_DATA = 256,
  parameter int SEG_W      = 16,
  parameter int SPC        = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [WIDTH_DATA-1:0] in_data,
  output logic                  busy,
  output logic                  out_valid,
  output logic [WIDTH_DATA-1:0] out_data
);

  localparam int NSEG  = nseg_f(WIDTH_DATA, SEG_W);
  localparam int CNT_W = cnt_w_f(NSEG);

  state_t                  state_p0, state_nxt;
  logic [WIDTH_DATA-1:0]   frame_p0, frame_nxt;
  logic [SEG_W-1:0]        acc_p0, acc_nxt, acc_sum;
  logic [CNT_W-1:0]        cnt_p0, cnt_nxt;
  logic [SPC*SEG_W-1:0]    segs;
  logic                    vld_p1, vld_nxt;
  logic [WIDTH_DATA-1:0]   out_data_p1, out_nxt;

  // Segment window cnt..cnt+SPC-1; indices past the last segment read as zero.
  always_comb begin
    segs = '0;
    for (int j = 0; j < SPC; j++) begin
      if (int'(cnt_p0) + j < NSEG) begin
        segs[j*SEG_W +: SEG_W] = SEG_W'(frame_p0 >> ((int'(cnt_p0) + j) * SEG_W));
      end
    end
  end

  cs_oc_adder #(
    .SEG_W (SEG_W),
    .SPC   (SPC)
  ) u_adder (
    .acc  (acc_p0),
    .segs (segs),
    .sum  (acc_sum)
  );

  // acc is kept folded every ACC cycle, so FOLD only has to invert it.
  always_comb begin
    state_nxt = state_p0;
    frame_nxt = frame_p0;
    acc_nxt   = acc_p0;
    cnt_nxt   = cnt_p0;
    vld_nxt   = 1'b0;
    out_nxt   = '0;
    unique case (state_p0)
      S_IDLE: begin
        if (in_valid) begin
          frame_nxt = in_data;
          acc_nxt   = '0;
          cnt_nxt   = CNT_W'(1);
          state_nxt = S_ACC;
        end
      end
      S_ACC: begin
        acc_nxt = acc_sum;
        cnt_nxt = cnt_p0 + CNT_W'(SPC);
        if (int'(cnt_p0) + SPC > NSEG - 1) begin
          state_nxt = S_FOLD;
        end
      end
      S_FOLD: begin
        vld_nxt   = 1'b1;
        out_nxt   = {frame_p0[WIDTH_DATA-1:SEG_W], ~acc_p0};
        state_nxt = S_OUT;
      end
      S_OUT: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0    <= S_IDLE;
      frame_p0    <= '0;
      acc_p0      <= '0;
      cnt_p0      <= '0;
      vld_p1      <= 1'b0;
      out_data_p1 <= '0;
    end else begin
      state_p0    <= state_nxt;
      frame_p0    <= frame_nxt;
      acc_p0      <= acc_nxt;
      cnt_p0      <= cnt_nxt;
      vld_p1      <= vld_nxt;
      out_data_p1 <= out_nxt;
    end
  end

  assign busy      = (state_p0 != S_IDLE);
  assign out_valid = vld_p1;
  assign out_data  = out_data_p1;

endmodule
